// File: rtl/awmf_chain_master.sv
// -----------------------------------------------------------------------------
// awmf_chain_master
//
// SPI master (CPOL=0 / CPHA=0) driving the AWMF daisy chain. One command is
// taken from the host handshake, turned into a serial frame and shifted out:
//   READ : 60*N_DEV bits on sdi, header {0, 0, addr[9:0]} followed by zeros.
//          The 48-bit response is captured from sdo_in at SCLK rising-edge
//          indices RD_OFS .. RD_OFS+47, MSB first.
//   PDI  : 62 bits on pdi, {1, 000, addr[9:0], data[47:0]}.
//   FBS  : 35 bits on pdi, {1, addr[9:0], data[23:0]}.
//   kind 3 is reserved: no pin activity, completes with rsp_err=1.
// After the frame, cs_n is held low for one half period, then released, and
// TRAIL_CLKS SCLK pulses are issued with cs_n high so the slaves can commit.
//
// Parameters
//   N_DEV       devices in the chain (1..8)
//   SCLK_HALF   clk cycles per SCLK half period (>= 2)
//   RD_OFS      SCLK rising-edge index of the first response bit
//   TRAIL_CLKS  SCLK pulses after cs_n rises (>= 1)
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   cmd_valid/ready     command handshake (ready only in IDLE)
//   cmd_kind/addr/data  command fields, latched at accept
//   rsp_valid           one-cycle completion pulse
//   rsp_kind/data/err   completion fields, held until the next completion
//   busy                high whenever the FSM is not IDLE
//   sclk, cs_n, sdi, pdi  registered chain drive
//   sdo_in              serial return from the end of the chain
//
// Optional build macro
//   AWMF_MASTER_XCHK_EN  when defined, any non-0/1 sdo_in sample inside the
//                        read capture window is reported and sets rsp_err.
//                        When undefined, sdo_in is sanitised (only a clean 1
//                        captures as 1) and rsp_err flags kind 3 only.
// -----------------------------------------------------------------------------
module awmf_chain_master #(
    parameter int N_DEV      = 4,
    parameter int SCLK_HALF  = 4,
    parameter int RD_OFS     = 13,
    parameter int TRAIL_CLKS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_kind,
    input  logic [9:0]  cmd_addr,
    input  logic [47:0] cmd_data,
    output logic        rsp_valid,
    output logic [1:0]  rsp_kind,
    output logic [47:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        sclk,
    output logic        cs_n,
    output logic        sdi,
    output logic        pdi,
    input  logic        sdo_in
);

    // -------------------------------------------------------------------------
    // Parameter sanity
    // -------------------------------------------------------------------------
    generate
        if (RD_OFS + 48 > 60 * N_DEV) begin : g_err_rd_ofs
            $error("awmf_chain_master: RD_OFS+48 exceeds the READ frame length 60*N_DEV");
        end
        if (N_DEV < 1 || N_DEV > 8) begin : g_err_n_dev
            $error("awmf_chain_master: N_DEV must be within 1..8");
        end
        if (SCLK_HALF < 2) begin : g_err_sclk_half
            $error("awmf_chain_master: SCLK_HALF must be at least 2");
        end
        if (TRAIL_CLKS < 1) begin : g_err_trail
            $error("awmf_chain_master: TRAIL_CLKS must be at least 1");
        end
        if (RD_OFS < 0) begin : g_err_rd_neg
            $error("awmf_chain_master: RD_OFS must not be negative");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int HCNT_W = (SCLK_HALF > 2) ? $clog2(SCLK_HALF) : 1;
    localparam int TCNT_W = (TRAIL_CLKS > 2) ? $clog2(TRAIL_CLKS) : 1;

    localparam logic [HCNT_W-1:0] HALF_LAST  = HCNT_W'(SCLK_HALF - 1);
    localparam logic [TCNT_W-1:0] TRAIL_LAST = TCNT_W'(TRAIL_CLKS - 1);

    localparam logic [8:0] RD_LEN    = 9'(60 * N_DEV);
    localparam logic [8:0] PDI_LEN   = 9'd62;
    localparam logic [8:0] FBS_LEN   = 9'd35;
    localparam logic [8:0] CAP_FIRST = 9'(RD_OFS);
    localparam logic [8:0] CAP_LAST  = 9'(RD_OFS + 47);

    localparam logic [1:0] KIND_READ = 2'd0;
    localparam logic [1:0] KIND_PDI  = 2'd1;
    localparam logic [1:0] KIND_FBS  = 2'd2;
    localparam logic [1:0] KIND_RSVD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_HOLD,
        ST_TRAIL_LO,
        ST_TRAIL_HI,
        ST_DONE
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [HCNT_W-1:0]   cnt_q, cnt_d;         // position within a half period
    logic [8:0]          bit_q, bit_d;         // bits completed, saturating
    logic [8:0]          len_q, len_d;         // frame length of the command
    logic [TCNT_W-1:0]   trail_q, trail_d;     // trailing pulses issued
    logic [1:0]          kind_q, kind_d;
    logic [61:0]         sr_q, sr_d;           // frame, current bit in [61]
    logic [47:0]         cap_q, cap_d;         // read response shift register
    logic [1:0]          rsp_kind_q, rsp_kind_d;
    logic [47:0]         rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                sclk_q, sclk_d;
    logic                cs_n_q, cs_n_d;
    logic                sdi_q, sdi_d;
    logic                pdi_q, pdi_d;

    logic [61:0]         frame_load;
    logic [8:0]          frame_len;
    logic                half_last;
    logic                in_window;
    logic                capture_now;
    logic                enter_done;
    logic                shifting_d;
    logic                sdo_bit;
    logic                xflag;

    // Only a clean logic 1 captures as 1; X/Z read as 0.
    assign sdo_bit   = (sdo_in === 1'b1);
    assign half_last = (cnt_q == HALF_LAST);
    assign in_window = (bit_q >= CAP_FIRST) && (bit_q <= CAP_LAST);

    // -------------------------------------------------------------------------
    // Frame construction. Every frame is MSB-aligned in a 62-bit shift
    // register; zeros fill from the bottom, which supplies the READ padding.
    // -------------------------------------------------------------------------
    always_comb begin
        frame_load = '0;
        frame_len  = PDI_LEN;
        case (cmd_kind)
            KIND_READ: begin
                frame_load = {2'b00, cmd_addr, 50'd0};
                frame_len  = RD_LEN;
            end
            KIND_PDI: begin
                frame_load = {1'b1, 3'b000, cmd_addr, cmd_data};
                frame_len  = PDI_LEN;
            end
            KIND_FBS: begin
                frame_load = {1'b1, cmd_addr, cmd_data[23:0], 27'd0};
                frame_len  = FBS_LEN;
            end
            default: begin
                frame_load = '0;
                frame_len  = PDI_LEN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        len_d       = len_q;
        trail_d     = trail_q;
        kind_d      = kind_q;
        sr_d        = sr_q;
        cap_d       = cap_q;
        rsp_kind_d  = rsp_kind_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        capture_now = 1'b0;
        enter_done  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    bit_d   = '0;
                    trail_d = '0;
                    kind_d  = cmd_kind;
                    len_d   = frame_len;
                    sr_d    = frame_load;
                    cap_d   = '0;
                end
            end

            ST_SETUP: begin
                if (kind_q == KIND_RSVD) begin
                    state_d    = ST_DONE;
                    enter_done = 1'b1;
                end else if (half_last) begin
                    state_d = ST_SHIFT_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + HCNT_W'(1);
                end
            end

            ST_SHIFT_LO: begin
                if (half_last) begin
                    // This edge raises sclk: sample the chain return here.
                    state_d     = ST_SHIFT_HI;
                    cnt_d       = '0;
                    capture_now = (kind_q == KIND_READ) && in_window;
                end else begin
                    cnt_d = cnt_q + HCNT_W'(1);
                end
            end

            ST_SHIFT_HI: begin
                if (half_last) begin
                    cnt_d = '0;
                    bit_d = (bit_q < len_q) ? bit_q + 9'd1 : bit_q;
                    if (bit_q >= len_q - 9'd1) begin
                        state_d = ST_HOLD;
                    end else begin
                        // Next bit appears together with the falling edge.
                        state_d = ST_SHIFT_LO;
                        sr_d    = {sr_q[60:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + HCNT_W'(1);
                end
            end

            ST_HOLD: begin
                if (half_last) begin
                    state_d = ST_TRAIL_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + HCNT_W'(1);
                end
            end

            ST_TRAIL_LO: begin
                if (half_last) begin
                    state_d = ST_TRAIL_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + HCNT_W'(1);
                end
            end

            ST_TRAIL_HI: begin
                if (half_last) begin
                    cnt_d = '0;
                    if (trail_q == TRAIL_LAST) begin
                        state_d    = ST_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = ST_TRAIL_LO;
                        trail_d = trail_q + TCNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + HCNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture_now) begin
            cap_d = {cap_q[46:0], sdo_bit};
        end

        // Response fields change only when a new completion is published.
        if (enter_done) begin
            rsp_kind_d = kind_q;
            rsp_data_d = (kind_q == KIND_READ) ? cap_q : 48'd0;
            rsp_err_d  = (kind_q == KIND_RSVD) || xflag;
        end

        // Pins are registered from the next state so they change cleanly
        // on the same edge as the FSM.
        shifting_d = (state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI);
        sclk_d     = (state_d == ST_SHIFT_HI) || (state_d == ST_TRAIL_HI);
        cs_n_d     = !(((state_d == ST_SETUP) && (kind_d != KIND_RSVD)) ||
                       shifting_d || (state_d == ST_HOLD));
        sdi_d      = shifting_d && (kind_d == KIND_READ) && sr_d[61];
        pdi_d      = shifting_d && (kind_d != KIND_READ) && sr_d[61];
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            len_q      <= PDI_LEN;
            trail_q    <= '0;
            kind_q     <= KIND_READ;
            sr_q       <= '0;
            cap_q      <= '0;
            rsp_kind_q <= 2'd0;
            rsp_data_q <= 48'd0;
            rsp_err_q  <= 1'b0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            sdi_q      <= 1'b0;
            pdi_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            len_q      <= len_d;
            trail_q    <= trail_d;
            kind_q     <= kind_d;
            sr_q       <= sr_d;
            cap_q      <= cap_d;
            rsp_kind_q <= rsp_kind_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            sdi_q      <= sdi_d;
            pdi_q      <= pdi_d;
        end
    end

    // -------------------------------------------------------------------------
    // Optional X detection on the read return
    // -------------------------------------------------------------------------
`ifdef AWMF_MASTER_XCHK_EN
    logic xflag_q;

    // Sticky per frame: cleared at accept, set by any non-0/1 sample taken
    // inside the capture window.
    always_ff @(posedge clk) begin
        if (rst) begin
            xflag_q <= 1'b0;
        end else if (state_q == ST_IDLE && cmd_valid && cmd_ready) begin
            xflag_q <= 1'b0;
        end else if (capture_now && (sdo_in !== 1'b0) && (sdo_in !== 1'b1)) begin
            xflag_q <= 1'b1;
            $display("AWMF XCHK: X on sdo_in bit %0d", bit_q);
        end
    end

    assign xflag = xflag_q;
`else
    assign xflag = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_kind  = rsp_kind_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign sclk      = sclk_q;
    assign cs_n      = cs_n_q;
    assign sdi       = sdi_q;
    assign pdi       = pdi_q;

endmodule

// File: tb/tb_awmf_chain_master.sv
// -----------------------------------------------------------------------------
// tb_awmf_chain_master
//
// Directed bench for awmf_chain_master with N_DEV=1, SCLK_HALF=2, RD_OFS=12,
// TRAIL_CLKS=2. A pin monitor records the bits shifted while cs_n is low,
// counts SCLK rising edges with cs_n low and high, and plays a one-device
// chain return on sdo_in (response word inside the capture window, ones
// outside it).
//
// Frame lengths L: READ 60, PDI 62, FBS 35.
// Accept-to-rsp_valid latency = 1 + 2*(2 + 2L + 4):
//   PDI 261, FBS 153, READ 253, reserved kind 2.
// -----------------------------------------------------------------------------
module tb_awmf_chain_master;

    localparam int N_DEV      = 1;
    localparam int SCLK_HALF  = 2;
    localparam int RD_OFS     = 12;
    localparam int TRAIL_CLKS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_kind = 2'd0;
    logic [9:0]  cmd_addr = 10'd0;
    logic [47:0] cmd_data = 48'd0;
    logic        rsp_valid;
    logic [1:0]  rsp_kind;
    logic [47:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        sclk;
    logic        cs_n;
    logic        sdi;
    logic        pdi;
    logic        sdo_in;

    awmf_chain_master #(
        .N_DEV      (N_DEV),
        .SCLK_HALF  (SCLK_HALF),
        .RD_OFS     (RD_OFS),
        .TRAIL_CLKS (TRAIL_CLKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_kind  (cmd_kind),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_kind  (rsp_kind),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .sdi       (sdi),
        .pdi       (pdi),
        .sdo_in    (sdo_in)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- monitor
    logic [47:0] rd_word   = 48'd0;   // response the emulated chain returns
    logic        sdo_drv   = 1'b1;
    logic        sclk_prev = 1'b0;
    logic        csn_prev  = 1'b1;
    int          lo_edges  = 0;
    int          hi_edges  = 0;
    int          tog_sclk  = 0;
    int          tog_csn   = 0;
    logic [63:0] sh_pdi    = 64'd0;
    logic [63:0] sh_sdi    = 64'd0;

    assign sdo_in = sdo_drv;

    function automatic logic resp_bit(input int k, input logic [47:0] w);
        if (k >= RD_OFS && k < RD_OFS + 48) return w[47 - (k - RD_OFS)];
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sclk !== sclk_prev) tog_sclk++;
            if (cs_n !== csn_prev) tog_csn++;
            if (!cs_n && csn_prev) begin
                lo_edges = 0;
                hi_edges = 0;
                sh_pdi   = 64'd0;
                sh_sdi   = 64'd0;
                sdo_drv  = resp_bit(0, rd_word);
            end
            if (sclk && !sclk_prev) begin
                if (!cs_n) begin
                    sh_pdi = {sh_pdi[62:0], pdi};
                    sh_sdi = {sh_sdi[62:0], sdi};
                    lo_edges++;
                    sdo_drv = resp_bit(lo_edges, rd_word);
                end else begin
                    hi_edges++;
                end
            end
            sclk_prev = sclk;
            csn_prev  = cs_n;
        end
    end

    // ------------------------------------------------------------- utilities
    task automatic issue(input logic [1:0] k, input logic [9:0] a, input logic [47:0] d,
                         output int acc_cyc);
        bit got;
        got = 1'b0;
        acc_cyc = -1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_kind  = k;
        cmd_addr  = a;
        cmd_data  = d;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                got = 1'b1;
                acc_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL accept_timeout: cmd_ready got 0 for 50 cycles, required 1");
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int rv_cyc);
        bit got;
        got = 1'b0;
        rv_cyc = -1;
        for (int i = 0; i < 2000; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                rv_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL rsp_timeout: rsp_valid got 0 for 2000 cycles, required 1");
        end
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({cs_n, sclk, sdi, pdi, cmd_ready, rsp_valid, rsp_err, busy} !== 8'b1000_1000) begin
            miscompares++;
            $display("FAIL reset_pins: {cs_n,sclk,sdi,pdi,rdy,vld,err,busy} got %b required 10001000",
                     {cs_n, sclk, sdi, pdi, cmd_ready, rsp_valid, rsp_err, busy});
        end
        vectors++;
        if ({rsp_kind, rsp_data} !== 50'd0) begin
            miscompares++;
            $display("FAIL reset_rsp: kind=%0d data=%h required 0/0", rsp_kind, rsp_data);
        end
        rst = 1'b0;
        $display("reset released at cycle %0d", cyc);
    endtask

    task automatic test_pdi();
        int acc, rv;
        issue(2'd1, 10'h155, 48'h1234_5678_9ABC, acc);
        wait_rsp(rv);
        $display("PDI addr=155 data=123456789abc acc=%0d rsp=%0d edges=%0d trail=%0d",
                 acc, rv, lo_edges, hi_edges);
        vectors++;
        if (rv - acc !== 261) begin
            miscompares++;
            $display("FAIL pdi_latency: got %0d required 261", rv - acc);
        end
        vectors++;
        if (lo_edges !== 62) begin
            miscompares++;
            $display("FAIL pdi_edges: got %0d required 62", lo_edges);
        end
        vectors++;
        if (sh_pdi !== 64'h2155_1234_5678_9ABC) begin
            miscompares++;
            $display("FAIL pdi_bits: got %h required 2155123456789abc", sh_pdi);
        end
        vectors++;
        if (sh_sdi !== 64'd0) begin
            miscompares++;
            $display("FAIL pdi_sdi_quiet: got %h required 0", sh_sdi);
        end
        vectors++;
        if (hi_edges !== 2) begin
            miscompares++;
            $display("FAIL pdi_trail: got %0d required 2", hi_edges);
        end
        vectors++;
        if ({rsp_kind, rsp_err, busy, cmd_ready} !== 5'b01_0_1_0) begin
            miscompares++;
            $display("FAIL pdi_done: {kind,err,busy,rdy} got %b required 01010",
                     {rsp_kind, rsp_err, busy, cmd_ready});
        end
        vectors++;
        if (rsp_data !== 48'd0) begin
            miscompares++;
            $display("FAIL pdi_rsp_data: got %h required 0", rsp_data);
        end
        @(negedge clk);
        vectors++;
        if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL pdi_idle: {vld,rdy,busy} got %b required 010", {rsp_valid, cmd_ready, busy});
        end
    endtask

    task automatic test_fbs();
        int acc, rv;
        issue(2'd2, 10'h02A, 48'hDEAD_00A5_A5A5, acc);
        wait_rsp(rv);
        $display("FBS addr=02a data=a5a5a5 acc=%0d rsp=%0d edges=%0d", acc, rv, lo_edges);
        vectors++;
        if (rv - acc !== 153) begin
            miscompares++;
            $display("FAIL fbs_latency: got %0d required 153", rv - acc);
        end
        vectors++;
        if (lo_edges !== 35) begin
            miscompares++;
            $display("FAIL fbs_edges: got %0d required 35", lo_edges);
        end
        vectors++;
        if (sh_pdi !== 64'h4_2AA5_A5A5) begin
            miscompares++;
            $display("FAIL fbs_bits: got %h required 42aa5a5a5", sh_pdi);
        end
        vectors++;
        if (rsp_kind !== 2'd2) begin
            miscompares++;
            $display("FAIL fbs_kind: got %0d required 2", rsp_kind);
        end
    endtask

    task automatic test_read();
        int acc, rv;
        rd_word = 48'hABCD_EF01_2345;
        issue(2'd0, 10'h03E, 48'hFFFF_FFFF_FFFF, acc);
        wait_rsp(rv);
        $display("READ addr=03e acc=%0d rsp=%0d edges=%0d data=%h", acc, rv, lo_edges, rsp_data);
        vectors++;
        if (rv - acc !== 253) begin
            miscompares++;
            $display("FAIL read_latency: got %0d required 253", rv - acc);
        end
        vectors++;
        if (lo_edges !== 60) begin
            miscompares++;
            $display("FAIL read_edges: got %0d required 60", lo_edges);
        end
        vectors++;
        if (sh_sdi !== 64'h003E_0000_0000_0000) begin
            miscompares++;
            $display("FAIL read_sdi_bits: got %h required 003e000000000000", sh_sdi);
        end
        vectors++;
        if (sh_pdi !== 64'd0) begin
            miscompares++;
            $display("FAIL read_pdi_quiet: got %h required 0", sh_pdi);
        end
        vectors++;
        if ({rsp_kind, rsp_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL read_kind_err: got %b required 000", {rsp_kind, rsp_err});
        end
        vectors++;
        if (rsp_data !== 48'hABCD_EF01_2345) begin
            miscompares++;
            $display("FAIL read_data: got %h required abcdef012345", rsp_data);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (rsp_data !== 48'hABCD_EF01_2345) begin
            miscompares++;
            $display("FAIL read_data_hold: got %h required abcdef012345", rsp_data);
        end
    endtask

    task automatic test_reserved();
        int acc, rv, ts, tc;
        ts = tog_sclk;
        tc = tog_csn;
        issue(2'd3, 10'h3FF, 48'h1, acc);
        wait_rsp(rv);
        $display("RSVD acc=%0d rsp=%0d err=%0d", acc, rv, rsp_err);
        vectors++;
        if (rv - acc !== 2) begin
            miscompares++;
            $display("FAIL rsvd_latency: got %0d required 2", rv - acc);
        end
        vectors++;
        if ({rsp_kind, rsp_err} !== 3'b111) begin
            miscompares++;
            $display("FAIL rsvd_kind_err: got %b required 111", {rsp_kind, rsp_err});
        end
        vectors++;
        if (rsp_data !== 48'd0) begin
            miscompares++;
            $display("FAIL rsvd_data: got %h required 0", rsp_data);
        end
        @(negedge clk);
        vectors++;
        if ((tog_sclk - ts) !== 0 || (tog_csn - tc) !== 0) begin
            miscompares++;
            $display("FAIL rsvd_pins_quiet: sclk toggles %0d cs_n toggles %0d required 0/0",
                     tog_sclk - ts, tog_csn - tc);
        end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, rv1, rv2, n_acc;
        acc1 = -1;
        acc2 = -1;
        rv1  = -1;
        n_acc = 0;
        rd_word = 48'h5A5A_0F0F_C3C3;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_kind  = 2'd2;
        cmd_addr  = 10'h111;
        cmd_data  = 48'h0000_0012_3456;
        for (int i = 0; i < 2000; i++) begin
            if (rsp_valid && rv1 < 0) begin
                rv1 = cyc;
                vectors++;
                if ({rsp_kind, rsp_err, cmd_ready} !== 4'b10_0_0) begin
                    miscompares++;
                    $display("FAIL b2b_first_done: {kind,err,rdy} got %b required 1000",
                             {rsp_kind, rsp_err, cmd_ready});
                end
            end
            if (cmd_ready) begin
                n_acc++;
                if (n_acc == 1) begin
                    acc1 = cyc;
                end else begin
                    acc2 = cyc;
                    break;
                end
            end
            @(negedge clk);
            if (n_acc == 1) begin
                cmd_kind = 2'd0;
                cmd_addr = 10'h0C3;
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("B2B acc1=%0d rsp1=%0d acc2=%0d", acc1, rv1, acc2);
        vectors++;
        if (rv1 - acc1 !== 153) begin
            miscompares++;
            $display("FAIL b2b_first_latency: got %0d required 153", rv1 - acc1);
        end
        vectors++;
        if (acc2 < 0 || acc2 - rv1 !== 1) begin
            miscompares++;
            $display("FAIL b2b_gap: second accept %0d cycles after rsp_valid, required 1", acc2 - rv1);
        end
        wait_rsp(rv2);
        $display("B2B second READ rsp=%0d data=%h", rv2, rsp_data);
        vectors++;
        if (rv2 - acc2 !== 253) begin
            miscompares++;
            $display("FAIL b2b_second_latency: got %0d required 253", rv2 - acc2);
        end
        vectors++;
        if (rsp_data !== 48'h5A5A_0F0F_C3C3) begin
            miscompares++;
            $display("FAIL b2b_read_data: got %h required 5a5a0f0fc3c3", rsp_data);
        end
        vectors++;
        if (sh_sdi !== 64'h00C3_0000_0000_0000) begin
            miscompares++;
            $display("FAIL b2b_sdi_bits: got %h required 00c3000000000000", sh_sdi);
        end
    endtask

    task automatic test_mid_reset();
        int acc, rv, ts, seen;
        issue(2'd1, 10'h155, 48'h1234_5678_9ABC, acc);
        repeat (40) @(negedge clk);
        vectors++;
        if ({busy, cs_n} !== 2'b10) begin
            miscompares++;
            $display("FAIL abort_midframe: {busy,cs_n} got %b required 10", {busy, cs_n});
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({cs_n, sclk, pdi, cmd_ready, rsp_valid, busy} !== 6'b100100) begin
            miscompares++;
            $display("FAIL abort_pins: {cs_n,sclk,pdi,rdy,vld,busy} got %b required 100100",
                     {cs_n, sclk, pdi, cmd_ready, rsp_valid, busy});
        end
        vectors++;
        if (rsp_data !== 48'd0) begin
            miscompares++;
            $display("FAIL abort_rsp_data: got %h required 0", rsp_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ts = tog_sclk;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        $display("ABORT PDI acc=%0d, idle cycles watched=300", acc);
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL abort_no_rsp: rsp_valid/busy cycles got %0d required 0", seen);
        end
        vectors++;
        if (tog_sclk - ts !== 0) begin
            miscompares++;
            $display("FAIL abort_no_trail: sclk toggles got %0d required 0", tog_sclk - ts);
        end
        issue(2'd2, 10'h001, 48'h00_0000_0001, acc);
        wait_rsp(rv);
        $display("FBS after abort acc=%0d rsp=%0d", acc, rv);
        vectors++;
        if (rv - acc !== 153) begin
            miscompares++;
            $display("FAIL abort_recover_latency: got %0d required 153", rv - acc);
        end
    endtask

    initial begin
        test_reset();
        test_pdi();
        test_fbs();
        test_read();
        test_reserved();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at 1 ms, required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/awmf_chain_master.md
# awmf_chain_master

Clock-divided SPI master that drives the AWMF daisy chain: generates `sclk`/`cs_n`, shifts a serial READ header on `sdi`, shifts 62-bit PDI or 35-bit FBS broadcast frames on `pdi`, and captures the 48-bit read response returning on the chain's `sdo`. It sits directly upstream of the first `awmf_slave` in the chain and is fed by a command/response handshake from the host-side controller. Mode is fixed at CPOL=0/CPHA=0. Trailing SCLK pulses with `cs_n` high let slaves commit on their CS-rise.

## Interface
- `N_DEV`, 4: devices in chain, 1..8.
- `SCLK_HALF`, 4: `clk` cycles per SCLK half-period, ≥2.
- `RD_OFS`, 13: SCLK rising-edge index (0-based) of the first response bit on `sdo_in`.
- `TRAIL_CLKS`, 2: SCLK pulses issued with `cs_n`=1 after each frame, ≥1.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_kind` in 2: 0=READ, 1=PDI, 2=FBS, 3=reserved.
- `cmd_addr` in 10: target address.
- `cmd_data` in 48: write data (FBS uses [23:0]).
- `rsp_valid` out 1: one-cycle pulse at completion.
- `rsp_kind` out 2: echo of accepted `cmd_kind`.
- `rsp_data` out 48: captured read data; 0 for non-READ.
- `rsp_err` out 1: reserved kind, or X on `sdo_in` (see Configuration).
- `busy` out 1: state ≠ IDLE.
- `sclk`, `cs_n`, `sdi`, `pdi` out 1 each: chain drive.
- `sdo_in` in 1: return from the chain.

## Operation
- Reset values: `cs_n`=1, `sclk`=0, `sdi`=0, `pdi`=0, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_kind`=0, `rsp_err`=0, `busy`=0.
- FSM: IDLE → SETUP → SHIFT_LO ⇄ SHIFT_HI → HOLD → TRAIL_LO ⇄ TRAIL_HI → DONE → IDLE.
- Accept when `cmd_valid && cmd_ready`. Latch kind, addr and data, build the frame, go to SETUP.
- Kind 3: no pin activity. Go directly to DONE with `rsp_err`=1.
- READ frame on `sdi`, MSB-first, length `60*N_DEV`: header12 = {1'b0 (read), 1'b0, addr[9:0]}, then zeros. `pdi` stays 0.
- PDI frame on `pdi`, 62 bits: {1'b1, 3'b000, addr[9:0], data[47:0]}. `sdi` stays 0.
- FBS frame on `pdi`, 35 bits: {1'b1, addr[9:0], data[23:0]}. `sdi` stays 0.
- Bit k is driven at SHIFT_LO entry and stays stable through the following SCLK high phase.
- READ capture: `sdo_in` is sampled at the `clk` edge that raises `sclk` for edge indices `RD_OFS`..`RD_OFS+47`. Bits shift into `rsp_data` MSB-first.
- `RD_OFS+48 > 60*N_DEV` is a parameter error (elaboration `$error`).
- Bit counter is 9 bits, saturating at frame length. No wrap.
- `rsp_*` outputs hold their values until the next DONE.

## Timing
- SETUP: `cs_n`=0, `sclk`=0 for `SCLK_HALF` cycles.
- Each bit: `SCLK_HALF` cycles low, then `SCLK_HALF` cycles high. Bit period is `2*SCLK_HALF` cycles.
- HOLD: after the last falling edge, `cs_n` stays 0 for `SCLK_HALF` cycles, then goes 1.
- TRAIL: `TRAIL_CLKS` full SCLK pulses with `cs_n`=1, `sdi`=`pdi`=0.
- DONE: one cycle. `rsp_valid`=1, `busy`=1, `cmd_ready`=0. Next cycle is IDLE.
- Total cycles from accept to `rsp_valid`: 1 + `SCLK_HALF`·(1 + 2·L + 1 + 2·`TRAIL_CLKS`), where L is the frame length.
- A command presented during DONE is not accepted until the following cycle.
- `rst` mid-frame: all outputs return to reset values on the next `clk` edge. No `rsp_valid` is issued for the aborted frame. Slaves see `cs_n` rise with no trailing clocks; no commit is guaranteed.
- `cmd_valid` while busy is ignored. The command is not queued.

## Configuration
- `AWMF_MASTER_XCHK_EN` defined: during the READ capture window, any `sdo_in` sample that is not 0 or 1 (`!==` check) sets a sticky flag for the frame. It also prints `$display("AWMF XCHK: X on sdo_in bit %0d")`. The flag drives `rsp_err` at DONE.
- Undefined: `sdo_in` is sanitised as `(sdo_in===1'b1)`. X or Z captures as 0. `rsp_err` reflects kind 3 only.

## Test plan
- Reset: hold `rst` 3 cycles mid-PDI frame → next cycle `cs_n`=1, `sclk`=0, `pdi`=0, no `rsp_valid`, `cmd_ready`=1.
- PDI with addr=0x155, data=0x123456789ABC, N_DEV=1 → 62 rising edges, `pdi` sequence {1,000,0x155,0x123456789ABC}, then 2 trailing pulses with `cs_n`=1. Slave regfile[0x155]=0x123456789ABC.
- FBS with addr=0x2A, data=0xA5A5A5 → 35 bits {1,0x02A,0xA5A5A5}. Slave regfile[0x2A]=0x000000A5A5A5.
- READ addr=0x03E, one `awmf_slave` attached, `RD_OFS` tuned → `rsp_data`=0xABCDEF012345, `rsp_err`=0, 60 rising edges under `cs_n`=0.
- Kind 3 → `rsp_valid` 2 cycles after accept, `rsp_err`=1, `sclk` and `cs_n` never toggle.
- Back-to-back commands with `cmd_valid` held → second accept exactly 1 cycle after `rsp_valid`. With XCHK enabled and `sdo_in`=X at bit `RD_OFS+5` → `rsp_err`=1.
